// File: rtl/com_rx4.sv
// com_rx4: nibble-serial frame receiver.
// A frame is a com_rxf pulse followed by nibbles (high first) forming
// HEAD, LEN, LEN payload bytes and an XOR checksum byte. Payload bytes are
// streamed out as they complete; the frame verdict follows the checksum.
module com_rx4 #(
  parameter logic [7:0] HEAD = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  com_rxd,
  input  logic        com_rxf,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_last,
  output logic        fire_read,
  output logic        rx_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_LEN,
    ST_DATA,
    ST_SUM
  } state_t;

  state_t      state, state_n;
  logic        phase, phase_n;
  logic [3:0]  hi, hi_n;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  acc, acc_n;
  logic [7:0]  data_n;
  logic        valid_n, last_n, fire_n, err_n, inc_n;
  logic [7:0]  byte_w;

  // The byte being completed this cycle: stored high nibble plus live low nibble.
  assign byte_w = {hi, com_rxd};

  // State, byte-assembly registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= 1'b0;
      cnt       <= 8'h00;
      acc       <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_last   <= 1'b0;
      fire_read <= 1'b0;
      rx_err    <= 1'b0;
      frame_cnt <= 16'h0000;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      rx_last   <= last_n;
      fire_read <= fire_n;
      rx_err    <= err_n;
      if (inc_n) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // High nibble holding register; pure data, so it is left out of reset.
  always_ff @(posedge clk) begin
    hi <= hi_n;
  end

  // Next-state, byte pairing and output decode.
  always_comb begin
    state_n = state;
    phase_n = phase;
    hi_n    = hi;
    cnt_n   = cnt;
    acc_n   = acc;
    data_n  = rx_data;
    valid_n = 1'b0;
    last_n  = 1'b0;
    fire_n  = 1'b0;
    err_n   = 1'b0;
    inc_n   = 1'b0;

    if (com_rxf && state != ST_IDLE) begin
      // A new frame start mid-frame discards the partial frame.
      err_n   = 1'b1;
      state_n = ST_HEAD;
      phase_n = 1'b0;
    end else if (state == ST_IDLE) begin
      if (com_rxf) begin
        state_n = ST_HEAD;
        phase_n = 1'b0;
      end
    end else if (!phase) begin
      hi_n    = com_rxd;
      phase_n = 1'b1;
    end else begin
      phase_n = 1'b0;
      case (state)
        ST_HEAD: begin
          if (byte_w == HEAD) begin
            state_n = ST_LEN;
          end else begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_LEN: begin
          if (byte_w == 8'h00) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end else begin
            cnt_n   = byte_w;
            acc_n   = 8'h00;
            state_n = ST_DATA;
          end
        end
        ST_DATA: begin
          data_n  = byte_w;
          valid_n = 1'b1;
          acc_n   = acc ^ byte_w;
          cnt_n   = cnt - 8'd1;
          if (cnt == 8'd1) begin
            last_n  = 1'b1;
            state_n = ST_SUM;
          end
        end
        ST_SUM: begin
          if (byte_w == acc) begin
            fire_n = 1'b1;
            inc_n  = 1'b1;
          end else begin
            err_n  = 1'b1;
          end
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule
